multiplexer: RTL and testbench
==============================

# multiplexer

AHB-Lite slave-to-master response multiplexer for the Triple-DES bus fabric. It selects the HREADYOUT, HRESP and 64-bit HRDATA of one of two slaves and drives them back to the master. Selection follows AHB data-phase rules: the address-phase select is registered and steers the returned response one transfer later. It sits between the address decoder (source of `muxSelect`) and the bus master.

## Interface
- `DATA_WIDTH`, default 64: width of the read-data buses.
- `HCLK`  in  1  bus clock; all state updates on the rising edge.
- `HRESETn`  in  1  reset, synchronous and active-low.
- `muxSelect`  in  1  address-phase slave select from the decoder: 0 selects slave 1, 1 selects slave 2.
- `HREADYOUT_1`  in  1  ready from slave 1.
- `HREADYOUT_2`  in  1  ready from slave 2.
- `HRESP_1`  in  1  response from slave 1: 0 is OKAY, 1 is ERROR.
- `HRESP_2`  in  1  response from slave 2.
- `HRDATA_1`  in  DATA_WIDTH  read data from slave 1.
- `HRDATA_2`  in  DATA_WIDTH  read data from slave 2.
- `HREADY`  out  1  selected ready, to the master and back to all slaves.
- `HRESP`  out  1  selected response.
- `HRDATA`  out  DATA_WIDTH  selected read data.

## Operation
- Internal register `dataSel` (1 bit) holds the data-phase select.
- `dataSel` is updated on the rising edge of `HCLK`:
  - If `HRESETn` = 0, it is set to 0.
  - Else if `HREADY` = 1, it loads `muxSelect`.
  - Else (wait state) it holds its value.
- Outputs are combinational from `dataSel` and the slave inputs:
  - When `dataSel` = 0: `HREADY` = `HREADYOUT_1`, `HRESP` = `HRESP_1`, `HRDATA` = `HRDATA_1`.
  - When `dataSel` = 1: the same outputs follow the slave-2 inputs.
- All three outputs always come from the same slave. Signals from the two slaves are never mixed.
- The non-selected slave's inputs have no effect on the outputs.
- The block performs no arithmetic and no width conversion. HRDATA passes through bit-for-bit, and all 64 bits must be exercised, including all-0 and all-1 patterns.

## Timing
- Reset value: `dataSel` = 0, so while and after reset the outputs mirror slave 1.
- Latency from a `muxSelect` change to output steering:
  - One `HCLK` edge, provided `HREADY` = 1 at that edge.
  - If `HREADY` = 0, the change is deferred until the first edge with `HREADY` = 1.
- Latency from a slave input change to the output: zero cycles, combinational. There is no register on the data path.
- Boundary cases:
  - A `muxSelect` toggle during a wait state is ignored unless still present at the completing edge.
  - An ERROR response with `HREADY` = 0 passes through unchanged.
  - Reset asserted mid-transfer forces `dataSel` to 0 at the next edge, regardless of `HREADY`.
  - Repeated identical `muxSelect` values cause no output glitch from the register.

## Structure
- Shared bus package holds:
  - `AHB_DATA_WIDTH` = 64.
  - HRESP encodings `HRESP_OKAY` = 1'b0 and `HRESP_ERROR` = 1'b1.
  - Select encodings `SEL_SLAVE1` = 1'b0 and `SEL_SLAVE2` = 1'b1.
- Single module containing one `always_ff` for `dataSel` and one `always_comb` for the output mux. No sub-module is warranted.
- Extending to N slaves is a future package/parameter change and is out of scope for this block.

## Test plan
- Reset: hold `HRESETn` = 0 for 2 edges with `HREADYOUT_1`=1, `HRESP_1`=1, `HRDATA_1`=0, `HRDATA_2`=all-ones. Required: `HREADY`=1, `HRESP`=1, `HRDATA`=64'h0.
- Switch to slave 2:
  - Stimulus: `muxSelect`=1, both ready=1, `HRESP_1`=1, `HRESP_2`=0, `HRDATA_1`=0, `HRDATA_2`=all-ones.
  - Before the edge: outputs still show slave 1.
  - After one edge: `HRESP`=0 and `HRDATA`=64'hFFFF_FFFF_FFFF_FFFF.
- Switch back with data patterns:
  - Stimulus: `muxSelect`=0, `HRDATA_1`=64'hABCDEF1234567890, `HRDATA_2`=64'h1234567890ABCDEF.
  - After one edge: `HRDATA`=64'hABCDEF1234567890 and `HRESP`=1.
- Wait-state hold:
  - Stimulus: `dataSel`=1, `HREADYOUT_2`=0, `muxSelect`=0 for 3 edges.
  - Required: outputs stay on slave 2 throughout. One edge after `HREADYOUT_2` rises, outputs move to slave 1.
- Isolation: with slave 1 selected, toggle every slave-2 input each cycle. Required: no change on `HREADY`, `HRESP` or `HRDATA`.
- Reset mid-transfer: with `dataSel`=1 and `HREADY`=0, assert `HRESETn`=0 for one edge. Required: outputs mirror slave 1 after that edge.

Source files
------------

// File: rtl/multiplexer_pkg.sv
// Shared AHB-Lite bus definitions for the Triple-DES fabric.
// Holds the bus data width and the HRESP / slave-select encodings used by the
// response multiplexer and its neighbours.
package multiplexer_pkg;

  localparam int unsigned AHB_DATA_WIDTH = 64;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Slave select encodings
  localparam logic SEL_SLAVE1 = 1'b0;
  localparam logic SEL_SLAVE2 = 1'b1;

endpackage

// File: rtl/multiplexer.sv
// AHB-Lite slave-to-master response multiplexer.
// Steers HREADYOUT, HRESP and HRDATA of one of two slaves back to the master.
// The address-phase select is registered so the response follows the
// data phase of the transfer it belongs to.
//
// Ports:
//   HCLK         in   bus clock, rising edge
//   HRESETn      in   synchronous active-low reset
//   muxSelect    in   address-phase select (0 = slave 1, 1 = slave 2)
//   HREADYOUT_1  in   ready from slave 1
//   HREADYOUT_2  in   ready from slave 2
//   HRESP_1      in   response from slave 1
//   HRESP_2      in   response from slave 2
//   HRDATA_1     in   read data from slave 1
//   HRDATA_2     in   read data from slave 2
//   HREADY       out  selected ready (to master and all slaves)
//   HRESP        out  selected response
//   HRDATA       out  selected read data
module multiplexer
  import multiplexer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AHB_DATA_WIDTH
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  muxSelect,
  input  logic                  HREADYOUT_1,
  input  logic                  HREADYOUT_2,
  input  logic                  HRESP_1,
  input  logic                  HRESP_2,
  input  logic [DATA_WIDTH-1:0] HRDATA_1,
  input  logic [DATA_WIDTH-1:0] HRDATA_2,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  // Data-phase select (dataSel). Only advances when the current transfer
  // completes, so a wait state keeps the response pinned to its slave.
  logic r_data_sel;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_data_sel <= SEL_SLAVE1;
    end else if (HREADY) begin
      r_data_sel <= muxSelect;
    end
  end

  // All three outputs come from the same slave; no register on this path.
  always_comb begin
    HREADY = HREADYOUT_1;
    HRESP  = HRESP_1;
    HRDATA = HRDATA_1;
    if (r_data_sel == SEL_SLAVE2) begin
      HREADY = HREADYOUT_2;
      HRESP  = HRESP_2;
      HRDATA = HRDATA_2;
    end
  end

endmodule

// File: tb/tb_multiplexer.sv
module tb_multiplexer;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PAT1 = 64'hABCD_EF12_3456_7890;
  localparam logic [63:0] PAT2 = 64'h1234_5678_90AB_CDEF;

  logic        HCLK;
  logic        HRESETn;
  logic        muxSelect;
  logic        HREADYOUT_1;
  logic        HREADYOUT_2;
  logic        HRESP_1;
  logic        HRESP_2;
  logic [63:0] HRDATA_1;
  logic [63:0] HRDATA_2;
  logic        HREADY;
  logic        HRESP;
  logic [63:0] HRDATA;

  int total;
  int bad;

  multiplexer #(
    .DATA_WIDTH(64)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .muxSelect  (muxSelect),
    .HREADYOUT_1(HREADYOUT_1),
    .HREADYOUT_2(HREADYOUT_2),
    .HRESP_1    (HRESP_1),
    .HRESP_2    (HRESP_2),
    .HRDATA_1   (HRDATA_1),
    .HRDATA_2   (HRDATA_2),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Checks all three outputs against one expected slave response.
  task automatic chk3(input string tag, input logic rdy, input logic rsp, input logic [63:0] dat);
    chk({tag, ".hready"}, {63'd0, HREADY}, {63'd0, rdy});
    chk({tag, ".hresp"},  {63'd0, HRESP},  {63'd0, rsp});
    chk({tag, ".hrdata"}, HRDATA, dat);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset
    HRESETn     = 1'b0;
    muxSelect   = 1'b0;
    HREADYOUT_1 = 1'b1;
    HREADYOUT_2 = 1'b1;
    HRESP_1     = 1'b1;
    HRESP_2     = 1'b0;
    HRDATA_1    = 64'h0;
    HRDATA_2    = ONES;
    tick();
    tick();
    chk3("reset", 1'b1, 1'b1, 64'h0);

    // Switch to slave 2
    HRESETn   = 1'b1;
    muxSelect = 1'b1;
    #1;
    chk3("sw2_pre", 1'b1, 1'b1, 64'h0);
    tick();
    chk3("sw2_post", 1'b1, 1'b0, ONES);

    // Switch back with data patterns
    muxSelect = 1'b0;
    HRDATA_1  = PAT1;
    HRDATA_2  = PAT2;
    #1;
    chk("sw1_pre.hrdata", HRDATA, PAT2);
    tick();
    chk3("sw1_post", 1'b1, 1'b1, PAT1);

    // Wait-state hold on slave 2, with ERROR passing through while not ready
    muxSelect = 1'b1;
    tick();
    chk3("ws_sel2", 1'b1, 1'b0, PAT2);
    HREADYOUT_2 = 1'b0;
    HRESP_2     = 1'b1;
    muxSelect   = 1'b0;
    #1;
    chk3("ws_err", 1'b0, 1'b1, PAT2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk3($sformatf("ws_hold%0d", i), 1'b0, 1'b1, PAT2);
    end
    HREADYOUT_2 = 1'b1;
    HRESP_2     = 1'b0;
    #1;
    chk3("ws_rise", 1'b1, 1'b0, PAT2);
    tick();
    chk3("ws_done", 1'b1, 1'b1, PAT1);

    // Toggle during wait state: only the value at the completing edge counts
    muxSelect = 1'b1;
    tick();
    chk("tg_sel2.hrdata", HRDATA, PAT2);
    HREADYOUT_2 = 1'b0;
    muxSelect   = 1'b0;
    tick();
    chk("tg_wait.hrdata", HRDATA, PAT2);
    muxSelect   = 1'b1;
    HREADYOUT_2 = 1'b1;
    tick();
    chk3("tg_done", 1'b1, 1'b0, PAT2);

    // Reset mid-transfer with HREADY low
    HREADYOUT_2 = 1'b0;
    HRESETn     = 1'b0;
    #1;
    chk("rmid_pre.hready", {63'd0, HREADY}, 64'd0);
    tick();
    chk3("rmid_post", 1'b1, 1'b1, PAT1);
    HRESETn = 1'b1;

    // Isolation: slave 1 selected, slave 2 inputs toggle every cycle
    muxSelect   = 1'b0;
    HRESP_1     = 1'b0;
    HRDATA_1    = 64'h5555_AAAA_0F0F_F0F0;
    HREADYOUT_2 = 1'b1;
    HRESP_2     = 1'b0;
    HRDATA_2    = 64'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      HREADYOUT_2 = ~HREADYOUT_2;
      HRESP_2     = ~HRESP_2;
      HRDATA_2    = ~HRDATA_2;
      #1;
      chk3($sformatf("iso%0d", i), 1'b1, 1'b0, 64'h5555_AAAA_0F0F_F0F0);
    end

    // Zero-latency pass-through of slave 1, all-zero and all-one patterns
    HRDATA_1 = 64'h0;
    #1;
    chk("pt_zero.hrdata", HRDATA, 64'h0);
    HRDATA_1 = ONES;
    HRESP_1  = 1'b1;
    #1;
    chk("pt_ones.hrdata", HRDATA, ONES);
    chk("pt_ones.hresp", {63'd0, HRESP}, 64'd1);

    // Slave 2 full-width patterns after reselect
    muxSelect = 1'b1;
    HREADYOUT_2 = 1'b1;
    HRESP_2   = 1'b0;
    HRDATA_2  = 64'h0;
    tick();
    chk3("s2_zero", 1'b1, 1'b0, 64'h0);
    HRDATA_2 = ONES;
    #1;
    chk("s2_ones.hrdata", HRDATA, ONES);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
